// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt entry / RTI return sequencer.
package interrupt_sequencer_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDrain,
    StPushPcHi,
    StPushPcLo,
    StPushFlags,
    StVecLo,
    StVecHi,
    StWritePc,
    StPopFlags,
    StPopPcLo,
    StPopPcHi,
    StRetPc
  } seq_state_e;

  localparam int unsigned FlagWidthDefault  = 3;
  localparam int unsigned VectorAddrDefault = 0;

  // Stack word order: pushed PC_HI, PC_LO, FLAGS; popped in reverse.
  localparam seq_state_e PushFirst = StPushPcHi;
  localparam seq_state_e PopFirst  = StPopFlags;

  // Successor of a stack-access state once its word has been transferred.
  function automatic seq_state_e stack_next(seq_state_e st);
    seq_state_e nxt;
    case (st)
      StPushPcHi:  nxt = StPushPcLo;
      StPushPcLo:  nxt = StPushFlags;
      StPushFlags: nxt = StVecLo;
      StPopFlags:  nxt = StPopPcLo;
      StPopPcLo:   nxt = StPopPcHi;
      StPopPcHi:   nxt = StRetPc;
      default:     nxt = StIdle;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_drain_counter.sv
// Loadable down-counter with a zero flag; counts pipeline drain bubbles.
module interrupt_sequencer_drain_counter
  import interrupt_sequencer_pkg::*;
#(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q;

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer: drains the pipeline, pushes PC and
// flags, fetches the handler vector, and reverses the stack on RTI.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FLAG_WIDTH   = FlagWidthDefault,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned VECTOR_ADDR  = VectorAddrDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  interrupt_signal,
  input  logic                  rti_decoded,
  input  logic [PC_WIDTH-1:0]   pc_resume,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fetch_stall,
  output logic                  flush_decode,
  output logic                  mem_push,
  output logic                  mem_pop,
  output logic                  mem_read,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  pc_write,
  output logic [PC_WIDTH-1:0]   pc_load_value,
  output logic                  flags_restore_en,
  output logic [FLAG_WIDTH-1:0] flags_restore,
  output logic                  in_isr,
  output logic                  busy
);

  localparam int unsigned CntWidth = $clog2(DRAIN_CYCLES + 1);

  seq_state_e            state_q;
  logic                  pending_q;
  logic                  in_isr_q;
  logic                  pop_first_q;
  logic [PC_WIDTH-1:0]   saved_pc_q;
  logic [FLAG_WIDTH-1:0] saved_flags_q;
  logic [FLAG_WIDTH-1:0] pop_flags_q;
  logic [DATA_WIDTH-1:0] vec_lo_q;
  logic [DATA_WIDTH-1:0] vec_hi_q;
  logic [DATA_WIDTH-1:0] pop_lo_q;
  logic [DATA_WIDTH-1:0] pop_hi_q;

  logic idle;
  logic rti_go;
  logic irq_go;
  logic drain_zero;

  // RTI has priority; an RTI outside a handler is ignored.
  assign idle   = (state_q == StIdle);
  assign rti_go = idle && rti_decoded && in_isr_q;
  assign irq_go = idle && pending_q && !in_isr_q && !rti_go;

  interrupt_sequencer_drain_counter #(
    .Width (CntWidth)
  ) u_drain_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (irq_go),
    .load_value (CntWidth'(DRAIN_CYCLES - 1)),
    .dec        (state_q == StDrain),
    .zero       (drain_zero)
  );

  // Sequencer state, pending request, handler flag and captured words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pending_q     <= 1'b0;
      in_isr_q      <= 1'b0;
      pop_first_q   <= 1'b0;
      saved_pc_q    <= '0;
      saved_flags_q <= '0;
      vec_lo_q      <= '0;
      vec_hi_q      <= '0;
      pop_flags_q   <= '0;
      pop_lo_q      <= '0;
      pop_hi_q      <= '0;
    end else begin
      pop_first_q <= 1'b0;
      if (interrupt_signal) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (rti_go) begin
            state_q     <= PopFirst;
            pop_first_q <= 1'b1;
          end else if (irq_go) begin
            state_q       <= StDrain;
            saved_pc_q    <= pc_resume;
            saved_flags_q <= flags_in;
            // A request on the acceptance edge itself starts a new pending one.
            pending_q     <= interrupt_signal;
          end
        end
        StDrain: begin
          if (drain_zero) begin
            state_q <= PushFirst;
          end
        end
        StPushPcHi, StPushPcLo, StPushFlags: begin
          if (mem_ready) begin
            state_q <= stack_next(state_q);
          end
        end
        StVecLo: begin
          if (mem_ready) begin
            vec_lo_q <= mem_rdata;
            state_q  <= StVecHi;
          end
        end
        StVecHi: begin
          if (mem_ready) begin
            vec_hi_q <= mem_rdata;
            state_q  <= StWritePc;
          end
        end
        StWritePc: begin
          in_isr_q <= 1'b1;
          state_q  <= StIdle;
        end
        StPopFlags: begin
          if (mem_ready) begin
            pop_flags_q <= mem_rdata[FLAG_WIDTH-1:0];
            state_q     <= stack_next(state_q);
          end
        end
        StPopPcLo: begin
          if (mem_ready) begin
            pop_lo_q <= mem_rdata;
            state_q  <= stack_next(state_q);
          end
        end
        StPopPcHi: begin
          if (mem_ready) begin
            pop_hi_q <= mem_rdata;
            state_q  <= stack_next(state_q);
          end
        end
        StRetPc: begin
          in_isr_q <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode only registered state, so they are stable for the whole cycle.
  always_comb begin
    fetch_stall      = !idle;
    busy             = !idle;
    in_isr           = in_isr_q;
    flush_decode     = 1'b0;
    mem_push         = 1'b0;
    mem_pop          = 1'b0;
    mem_read         = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    pc_write         = 1'b0;
    pc_load_value    = '0;
    flags_restore_en = 1'b0;
    flags_restore    = '0;
    unique case (state_q)
      StDrain: flush_decode = 1'b1;
      StPushPcHi: begin
        mem_push  = 1'b1;
        mem_wdata = saved_pc_q[PC_WIDTH-1 -: DATA_WIDTH];
      end
      StPushPcLo: begin
        mem_push  = 1'b1;
        mem_wdata = saved_pc_q[DATA_WIDTH-1:0];
      end
      StPushFlags: begin
        mem_push  = 1'b1;
        mem_wdata = DATA_WIDTH'(saved_flags_q);
      end
      StVecLo: begin
        mem_read = 1'b1;
        mem_addr = DATA_WIDTH'(VECTOR_ADDR);
      end
      StVecHi: begin
        mem_read = 1'b1;
        mem_addr = DATA_WIDTH'(VECTOR_ADDR + 1);
      end
      StWritePc: begin
        flush_decode  = 1'b1;
        pc_write      = 1'b1;
        pc_load_value = PC_WIDTH'({vec_hi_q, vec_lo_q});
      end
      StPopFlags: begin
        mem_pop      = 1'b1;
        flush_decode = pop_first_q;
      end
      StPopPcLo, StPopPcHi: mem_pop = 1'b1;
      StRetPc: begin
        flush_decode     = 1'b1;
        pc_write         = 1'b1;
        pc_load_value    = PC_WIDTH'({pop_hi_q, pop_lo_q});
        flags_restore_en = 1'b1;
        flags_restore    = pop_flags_q;
      end
      default: ;
    endcase
  end

endmodule
